// File: rtl/ysyx_25040129_csr_seq_pkg.sv
// ysyx_25040129_csr_seq_pkg: op encodings, CSR addresses, FSM states and mstatus trap helper
package ysyx_25040129_csr_seq_pkg;
    localparam logic [2:0] OP_RW = 3'd0;
    localparam logic [2:0] OP_RS = 3'd1;
    localparam logic [2:0] OP_RC = 3'd2;
    localparam logic [2:0] OP_ECALL = 3'd3;
    localparam logic [2:0] OP_MRET = 3'd4;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC = 12'h305;
    localparam logic [11:0] CSR_MEPC = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam int MST_MIE = 3;
    localparam int MST_MPIE = 7;
    localparam int MST_MPP = 11;
    typedef enum logic [2:0] {IDLE, RD, WR, T_EPC, T_VEC, RET, RESP, T_MST} state_e;
    function automatic logic [31:0] mstatus_upd(input logic [31:0] m, input logic ret);
        logic [31:0] r;
        r = m;
        r[MST_MPP+:2] = 2'b11;
        r[MST_MIE] = ret ? m[MST_MPIE] : 1'b0;
        r[MST_MPIE] = ret ? 1'b1 : m[MST_MIE];
        return r;
    endfunction
endpackage

// File: rtl/ysyx_25040129_csr_seq_if.sv
// ysyx_25040129_csr_seq_if: core request/response handshake plus CSR file port
interface ysyx_25040129_csr_seq_if #(parameter int CSR_AW = 12, parameter int XLEN = 32);
    logic req_valid, req_ready, req_src_zero;
    logic [2:0] req_op;
    logic [CSR_AW-1:0] req_addr;
    logic [XLEN-1:0] req_src, req_pc;
    logic resp_valid, resp_redirect;
    logic [XLEN-1:0] resp_rdata, resp_npc;
    logic [CSR_AW-1:0] csr_read_addr, csr_write_addr;
    logic [XLEN-1:0] csr_out, csr_data;
    logic csr_write;
    modport master(
        output req_valid, req_op, req_addr, req_src, req_src_zero, req_pc, csr_out,
        input req_ready, resp_valid, resp_rdata, resp_redirect, resp_npc,
        input csr_read_addr, csr_write, csr_write_addr, csr_data
    );
    modport slave(
        input req_valid, req_op, req_addr, req_src, req_src_zero, req_pc, csr_out,
        output req_ready, resp_valid, resp_rdata, resp_redirect, resp_npc,
        output csr_read_addr, csr_write, csr_write_addr, csr_data
    );
endinterface

// File: rtl/ysyx_25040129_csr_alu.sv
// ysyx_25040129_csr_alu: new CSR value and write enable for CSRRW/CSRRS/CSRRC
module ysyx_25040129_csr_alu
    import ysyx_25040129_csr_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] old,
    input  logic [XLEN-1:0] src,
    input  logic            src_zero,
    output logic [XLEN-1:0] nval,
    output logic            wen
);
    assign nval = op == OP_RW ? src : op == OP_RS ? (old | src) : (old & ~src);
    assign wen = op == OP_RW || !src_zero;
endmodule

// File: rtl/ysyx_25040129_csr_seq.sv
// ysyx_25040129_csr_seq: multi-cycle CSR port sequencer for CSRRW/RS/RC, ECALL and MRET.
// Defining YSYX_25040129_TRAP_MSTATUS_EN adds the mstatus update step to ECALL and MRET.
module ysyx_25040129_csr_seq
    import ysyx_25040129_csr_seq_pkg::*;
#(
    parameter int CSR_AW = 12,
    parameter int XLEN = 32
) (
    input logic clk,
    input logic rst,
    ysyx_25040129_csr_seq_if.slave bus
);
`ifdef YSYX_25040129_TRAP_MSTATUS_EN
    localparam state_e AFTER_EPC = T_MST;
    localparam state_e AFTER_RET = T_MST;
`else
    localparam state_e AFTER_EPC = T_VEC;
    localparam state_e AFTER_RET = RESP;
`endif
    state_e state, nxt;
    logic [2:0] op_q;
    logic [CSR_AW-1:0] addr_q;
    logic [XLEN-1:0] src_q, pc_q, old_q, nval_q, npc_q, alu_nval;
    logic zero_q, alu_wen, wr;
    ysyx_25040129_csr_alu #(.XLEN(XLEN)) u_alu (
        .op(op_q), .old(bus.csr_out), .src(src_q), .src_zero(zero_q), .nval(alu_nval), .wen(alu_wen)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            op_q <= '0;
            addr_q <= '0;
            src_q <= '0;
            zero_q <= 1'b0;
            pc_q <= '0;
            old_q <= '0;
            nval_q <= '0;
            npc_q <= '0;
        end else begin
            state <= nxt;
            if (state == IDLE && bus.req_valid) begin
                op_q <= bus.req_op;
                addr_q <= bus.req_addr;
                src_q <= bus.req_src;
                zero_q <= bus.req_src_zero;
                pc_q <= bus.req_pc;
                old_q <= '0;
                npc_q <= '0;
            end
            if (state == RD) begin
                old_q <= bus.csr_out;
                nval_q <= alu_nval;
            end
            if (state == T_VEC) npc_q <= bus.csr_out & ~XLEN'(3);
            if (state == RET) npc_q <= bus.csr_out;
        end
    end
    always_comb begin
        nxt = state;
        wr = 1'b0;
        bus.req_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = '0;
        bus.resp_redirect = 1'b0;
        bus.resp_npc = '0;
        bus.csr_read_addr = '0;
        bus.csr_write_addr = '0;
        bus.csr_data = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    nxt = bus.req_op < OP_ECALL ? RD : bus.req_op == OP_ECALL ? T_EPC :
                          bus.req_op == OP_MRET ? RET : RESP;
            end
            RD: begin
                bus.csr_read_addr = addr_q;
                nxt = alu_wen ? WR : RESP;
            end
            WR: begin
                wr = 1'b1;
                bus.csr_write_addr = addr_q;
                bus.csr_data = nval_q;
                nxt = RESP;
            end
            T_EPC: begin
                wr = 1'b1;
                bus.csr_write_addr = CSR_AW'(CSR_MEPC);
                bus.csr_data = pc_q;
                nxt = AFTER_EPC;
            end
            T_MST: begin
                wr = 1'b1;
                bus.csr_read_addr = CSR_AW'(CSR_MSTATUS);
                bus.csr_write_addr = CSR_AW'(CSR_MSTATUS);
                bus.csr_data = XLEN'(mstatus_upd(32'(bus.csr_out), op_q == OP_MRET));
                nxt = op_q == OP_ECALL ? T_VEC : RESP;
            end
            T_VEC: begin
                bus.csr_read_addr = CSR_AW'(CSR_MTVEC);
                nxt = RESP;
            end
            RET: begin
                bus.csr_read_addr = CSR_AW'(CSR_MEPC);
                nxt = AFTER_RET;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_rdata = old_q;
                bus.resp_redirect = op_q == OP_ECALL || op_q == OP_MRET;
                bus.resp_npc = npc_q;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        // a write pending while reset is held is dropped, not issued
        bus.csr_write = wr && !rst;
    end
endmodule

// File: tb/tb_ysyx_25040129_csr_seq.sv
// tb_ysyx_25040129_csr_seq: directed bench with a behavioural CSR file model
module tb_ysyx_25040129_csr_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    logic [31:0] mem [4096];
    logic tb_we = 1'b0;
    logic [11:0] tb_wa = '0;
    logic [31:0] tb_wd = '0;
    ysyx_25040129_csr_seq_if bus ();
    ysyx_25040129_csr_seq dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always_comb bus.csr_out = mem[bus.csr_read_addr];
    always @(posedge clk) begin
        if (bus.csr_write) mem[bus.csr_write_addr] <= bus.csr_data;
        if (tb_we) mem[tb_wa] <= tb_wd;
    end
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask
    task automatic do_op(input string tag, input logic [2:0] op, input logic [11:0] a, input logic [31:0] s,
                         input logic z, input logic [31:0] pc, input int lat, input logic [31:0] rd,
                         input logic redir, input logic [31:0] npc, input int nw,
                         input logic [11:0] ewa, input logic [31:0] ewd, input int ewc);
        int n, w, wc;
        logic [11:0] wa;
        logic [31:0] wd;
        w = 0; wc = 0; wa = '0; wd = '0;
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_addr = a;
        bus.req_src = s;
        bus.req_src_zero = z;
        bus.req_pc = pc;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.resp_valid && n < 10) begin
            if (bus.csr_write) begin
                w++; wc = n; wa = bus.csr_write_addr; wd = bus.csr_data;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_rdata"}, bus.resp_rdata, rd);
        check({tag, "_redir"}, 32'(bus.resp_redirect), 32'(redir));
        if (redir) check({tag, "_npc"}, bus.resp_npc, npc);
        check({tag, "_nwr"}, 32'(w), 32'(nw));
        if (nw > 0) begin
            check({tag, "_waddr"}, 32'(wa), 32'(ewa));
            check({tag, "_wdata"}, wd, ewd);
            if (ewc > 0) check({tag, "_wcyc"}, 32'(wc), 32'(ewc));
        end
        @(negedge clk);
        check({tag, "_idle"}, {30'd0, bus.req_ready, bus.resp_valid}, 32'b10);
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_op = '0;
        bus.req_addr = '0;
        bus.req_src = '0;
        bus.req_src_zero = 1'b0;
        bus.req_pc = '0;
        @(negedge clk);
        preload(12'h305, 32'h0);
        preload(12'h300, 32'h0);
        preload(12'h341, 32'h0);
        preload(12'h340, 32'h1234);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("reset_idle", {29'd0, bus.req_ready, bus.csr_write, bus.resp_valid}, 32'b100);
            check("reset_data", bus.csr_data | 32'(bus.csr_write_addr) | bus.resp_rdata, 32'd0);
        end
        do_op("rw_mtvec", 3'd0, 12'h305, 32'h8000_0100, 1'b0, 32'h0, 3, 32'h0, 1'b0, 32'h0, 1,
              12'h305, 32'h8000_0100, 2);
        check("mtvec_val", mem[12'h305], 32'h8000_0100);
        do_op("rs_mst", 3'd1, 12'h300, 32'h8, 1'b0, 32'h0, 3, 32'h0, 1'b0, 32'h0, 1, 12'h300, 32'h8, 2);
        do_op("rc_mst", 3'd2, 12'h300, 32'h8, 1'b0, 32'h0, 3, 32'h8, 1'b0, 32'h0, 1, 12'h300, 32'h0, 2);
        check("mst_val", mem[12'h300], 32'h0);
        do_op("rs_zero", 3'd1, 12'h300, 32'h0, 1'b1, 32'h0, 2, 32'h0, 1'b0, 32'h0, 0, 12'h0, 32'h0, 0);
        do_op("rw_rmw", 3'd0, 12'h340, 32'hABCD, 1'b0, 32'h0, 3, 32'h1234, 1'b0, 32'h0, 1,
              12'h340, 32'hABCD, 2);
        preload(12'h305, 32'h8000_0103);
        do_op("ecall", 3'd3, 12'h0, 32'h0, 1'b0, 32'h8000_0040, 3, 32'h0, 1'b1, 32'h8000_0100, 1,
              12'h341, 32'h8000_0040, 1);
        check("ecall_mst", mem[12'h300], 32'h0);
        preload(12'h341, 32'h8000_0044);
        do_op("mret", 3'd4, 12'h0, 32'h0, 1'b0, 32'h0, 2, 32'h0, 1'b1, 32'h8000_0044, 0, 12'h0, 32'h0, 0);
        do_op("illegal", 3'd5, 12'h300, 32'hFFFF_FFFF, 1'b0, 32'h0, 1, 32'h0, 1'b0, 32'h0, 0,
              12'h0, 32'h0, 0);
        bus.req_valid = 1'b1;
        bus.req_op = 3'd0;
        bus.req_addr = 12'h340;
        bus.req_src = 32'h5555;
        bus.req_src_zero = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_wr", 32'(bus.csr_write), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_gate", 32'(bus.csr_write), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {29'd0, bus.req_ready, bus.csr_write, bus.resp_valid}, 32'b100);
        @(negedge clk);
        check("abort_after", {29'd0, bus.req_ready, bus.csr_write, bus.resp_valid}, 32'b100);
        check("abort_mem", mem[12'h340], 32'hABCD);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
